// File: rtl/uid_auth_table.sv
// uid_auth_table: volatile access-control table that sits behind the ESP32
// frame parser. One decoded command (check / add / delete UID) is accepted
// at a time. Each command runs a sequential scan over a register-based UID
// store and finishes with a one-cycle done strobe carrying the result flags.
module uid_auth_table #(
  parameter int         N_ENTRIES     = 8,
  parameter int         UID_MAX_BYTES = 10,
  parameter logic [7:0] CMD_CHECK     = 8'h10,
  parameter logic [7:0] CMD_ADD       = 8'h11,
  parameter logic [7:0] CMD_DEL       = 8'h12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid,
  input  logic [7:0]                     cmd,
  input  logic [8*UID_MAX_BYTES-1:0]     uid,
  input  logic [7:0]                     uid_len,
  output logic                           busy,
  output logic                           done,
  output logic                           uid_allowed,
  output logic                           uid_added_ok,
  output logic                           uid_duplicate,
  output logic                           uid_full,
  output logic                           uid_removed,
  output logic                           err_len,
  output logic                           err_cmd,
  output logic [$clog2(N_ENTRIES+1)-1:0] count
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int UID_W = 8 * UID_MAX_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // UID store: bytes at or beyond a slot's length are always held at zero,
  // which lets a whole-vector compare stand in for a length-limited compare.
  logic             slot_valid [N_ENTRIES];
  logic [7:0]       slot_len   [N_ENTRIES];
  logic [UID_W-1:0] slot_data  [N_ENTRIES];

  // Latched command and scan bookkeeping
  logic [7:0]       cmd_q;
  logic [UID_W-1:0] uid_q;
  logic [7:0]       len_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] free_idx_q;
  logic [IDX_W-1:0] match_idx_q;
  logic             free_found_q;
  logic             match_q;

  logic [UID_W-1:0] uid_masked;
  logic             len_bad;
  logic             cmd_bad;
  logic             cur_match;
  logic             last_idx;

  // Zero the incoming UID bytes beyond uid_len so they line up with the store
  always_comb begin
    uid_masked = '0;
    for (int b = 0; b < UID_MAX_BYTES; b++) begin
      if (b < int'(uid_len)) begin
        uid_masked[b*8 +: 8] = uid[b*8 +: 8];
      end
    end
  end

  // Classify the incoming command and compare the slot currently under scan
  always_comb begin
    len_bad   = (uid_len == 8'd0) || (int'(uid_len) > UID_MAX_BYTES);
    cmd_bad   = (cmd != CMD_CHECK) && (cmd != CMD_ADD) && (cmd != CMD_DEL);
    cur_match = slot_valid[idx_q] && (slot_len[idx_q] == len_q) &&
                (slot_data[idx_q] == uid_q);
    last_idx  = (idx_q == IDX_W'(N_ENTRIES - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: errors skip the scan, a match exits the scan early
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = (len_bad || cmd_bad) ? S_RESP : S_SCAN;
        end
      end
      S_SCAN: begin
        if (cur_match || last_idx) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command latch, scan bookkeeping, result flags, busy/done and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q         <= '0;
      uid_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      free_idx_q    <= '0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      match_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      uid_allowed   <= 1'b0;
      uid_added_ok  <= 1'b0;
      uid_duplicate <= 1'b0;
      uid_full      <= 1'b0;
      uid_removed   <= 1'b0;
      err_len       <= 1'b0;
      err_cmd       <= 1'b0;
      count         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (valid) begin
            cmd_q         <= cmd;
            uid_q         <= uid_masked;
            len_q         <= uid_len;
            idx_q         <= '0;
            free_found_q  <= 1'b0;
            match_q       <= 1'b0;
            busy          <= 1'b1;
            uid_allowed   <= 1'b0;
            uid_added_ok  <= 1'b0;
            uid_duplicate <= 1'b0;
            uid_full      <= 1'b0;
            uid_removed   <= 1'b0;
            err_len       <= len_bad;
            err_cmd       <= !len_bad && cmd_bad;
          end
        end
        S_SCAN: begin
          if (cur_match) begin
            match_q     <= 1'b1;
            match_idx_q <= idx_q;
          end else begin
            if (!slot_valid[idx_q] && !free_found_q) begin
              free_found_q <= 1'b1;
              free_idx_q   <= idx_q;
            end
            if (!last_idx) begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_COMMIT: begin
          if (cmd_q == CMD_CHECK) begin
            uid_allowed <= match_q;
          end else if (cmd_q == CMD_ADD) begin
            if (match_q) begin
              uid_duplicate <= 1'b1;
            end else if (free_found_q) begin
              uid_added_ok <= 1'b1;
              count        <= count + CNT_W'(1);
            end else begin
              uid_full <= 1'b1;
            end
          end else if (cmd_q == CMD_DEL) begin
            if (match_q) begin
              uid_removed <= 1'b1;
              count       <= count - CNT_W'(1);
            end
          end
        end
        S_RESP: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Table update: add writes the lowest free slot, delete clears the match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        slot_valid[i] <= 1'b0;
        slot_len[i]   <= '0;
        slot_data[i]  <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      if (cmd_q == CMD_ADD && !match_q && free_found_q) begin
        slot_valid[free_idx_q] <= 1'b1;
        slot_len[free_idx_q]   <= len_q;
        slot_data[free_idx_q]  <= uid_q;
      end else if (cmd_q == CMD_DEL && match_q) begin
        slot_valid[match_idx_q] <= 1'b0;
        slot_len[match_idx_q]   <= '0;
        slot_data[match_idx_q]  <= '0;
      end
    end
  end

endmodule
